// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-address types, forward selects and compare helpers
package mips_pkg;

  localparam int REG_W     = 5;
  localparam int DIV_CNT_W = 6;

  typedef logic [REG_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // $zero is hard-wired, so it never creates a dependence
  function automatic logic reg_hit(input reg_addr_t src, input reg_addr_t dst, input logic en);
    return en && (src != REG_ZERO) && (src == dst);
  endfunction

  function automatic fwd_sel_e fwd_sel(input reg_addr_t src,
                                       input reg_addr_t dest_m, input logic regwrite_m,
                                       input reg_addr_t dest_w, input logic regwrite_w);
    if (reg_hit(src, dest_m, regwrite_m)) return FWD_MEM;
    if (reg_hit(src, dest_w, regwrite_w)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_unit_if;
  import mips_pkg::*;

  reg_addr_t  rs_d;
  reg_addr_t  rt_d;
  logic       branch_d;
  logic       hilo_read_d;
  logic       div_d;
  reg_addr_t  rs_e;
  reg_addr_t  rt_e;
  reg_addr_t  dest_e;
  logic       regwrite_e;
  logic       memtoreg_e;
  logic       div_start_e;

  logic [1:0] fwd_a_e;
  logic [1:0] fwd_b_e;
  logic       fwd_a_d;
  logic       fwd_b_d;
  logic       stall_f;
  logic       stall_d;
  logic       flush_e;
  logic       div_busy;

  modport master (
    output rs_d, rt_d, branch_d, hilo_read_d, div_d,
    output rs_e, rt_e, dest_e, regwrite_e, memtoreg_e, div_start_e,
    input  fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e, div_busy
  );

  modport slave (
    input  rs_d, rt_d, branch_d, hilo_read_d, div_d,
    input  rs_e, rt_e, dest_e, regwrite_e, memtoreg_e, div_start_e,
    output fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall_f, stall_d, flush_e, div_busy
  );

endinterface

// File: rtl/div_busy_ctr.sv
// rtl/div_busy_ctr.sv - divider occupancy counter: loads on an idle start, counts down to zero
module div_busy_ctr
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic clr,
  input  logic start_i,
  output logic busy_o
);

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

  // a start while busy is dropped rather than restarting the count
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_CNT_W'(1);
    end else if (start_i) begin
      cnt_d = DIV_CNT_W'(DIV_CYCLES);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - MIPS forwarding/stall/flush controller with shadow M/W destination state
// Define HAZARD_DIV_EN to include the divider busy counter and its hi/lo stall.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input logic         clk,
  input logic         clr,
  hazard_unit_if.slave hz
);

  reg_addr_t dest_m_q, dest_w_q;
  logic      regwrite_m_q, memtoreg_m_q, regwrite_w_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dest_m_q     <= REG_ZERO;
      regwrite_m_q <= 1'b0;
      memtoreg_m_q <= 1'b0;
      dest_w_q     <= REG_ZERO;
      regwrite_w_q <= 1'b0;
    end else begin
      dest_m_q     <= hz.dest_e;
      regwrite_m_q <= hz.regwrite_e;
      memtoreg_m_q <= hz.memtoreg_e;
      dest_w_q     <= dest_m_q;
      regwrite_w_q <= regwrite_m_q;
    end
  end

  logic div_busy;
  logic divstall;

`ifdef HAZARD_DIV_EN
  div_busy_ctr #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_busy_ctr (
    .clk     (clk),
    .clr     (clr),
    .start_i (hz.div_start_e),
    .busy_o  (div_busy)
  );

  assign divstall = div_busy && (hz.hilo_read_d || hz.div_d);
`else
  logic unused_div_ok;
  assign unused_div_ok = (^{hz.div_start_e, hz.div_d, hz.hilo_read_d}) ^ (DIV_CYCLES == 0);
  assign div_busy      = 1'b0;
  assign divstall      = 1'b0;
`endif

  logic lwstall, brstall, stall;

  assign lwstall = hz.memtoreg_e &&
                   (reg_hit(hz.rs_d, hz.dest_e, 1'b1) || reg_hit(hz.rt_d, hz.dest_e, 1'b1));

  // a decode-stage branch cannot take a value still in the ALU or a load still in memory
  assign brstall = hz.branch_d &&
                   (reg_hit(hz.rs_d, hz.dest_e, hz.regwrite_e) ||
                    reg_hit(hz.rt_d, hz.dest_e, hz.regwrite_e) ||
                    reg_hit(hz.rs_d, dest_m_q, memtoreg_m_q)   ||
                    reg_hit(hz.rt_d, dest_m_q, memtoreg_m_q));

  assign stall = lwstall || brstall || divstall;

  // every output is held low while clr is asserted, even if inputs would stall
  always_comb begin
    hz.fwd_a_e  = FWD_RF;
    hz.fwd_b_e  = FWD_RF;
    hz.fwd_a_d  = 1'b0;
    hz.fwd_b_d  = 1'b0;
    hz.stall_f  = 1'b0;
    hz.stall_d  = 1'b0;
    hz.flush_e  = 1'b0;
    hz.div_busy = 1'b0;
    if (!clr) begin
      hz.fwd_a_e  = fwd_sel(hz.rs_e, dest_m_q, regwrite_m_q, dest_w_q, regwrite_w_q);
      hz.fwd_b_e  = fwd_sel(hz.rt_e, dest_m_q, regwrite_m_q, dest_w_q, regwrite_w_q);
      hz.fwd_a_d  = reg_hit(hz.rs_d, dest_m_q, regwrite_m_q);
      hz.fwd_b_d  = reg_hit(hz.rt_d, dest_m_q, regwrite_m_q);
      hz.stall_f  = stall;
      hz.stall_d  = stall;
      hz.flush_e  = stall;
      hz.div_busy = div_busy;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - vector-table and scoreboard bench for hazard_unit
module tb_hazard_unit;
    import mips_pkg::*;

    localparam int DIVN = 4;
`ifdef HAZARD_DIV_EN
    localparam logic B = 1'b1;
`else
    localparam logic B = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    hazard_unit_if hz();

    hazard_unit #(.DIV_CYCLES(DIVN)) dut (
        .clk (clk),
        .clr (clr),
        .hz  (hz)
    );

    typedef struct {
        string      name;
        logic [4:0] rs_d, rt_d;
        logic       br, hilo, dv;
        logic [4:0] rs_e, rt_e, dest_e;
        logic       rw, mtr, dst;
        logic [9:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[$];
    vec_t dtbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input string n,
                                input logic [4:0] rs_d, input logic [4:0] rt_d,
                                input logic br, input logic hilo, input logic dv,
                                input logic [4:0] rs_e, input logic [4:0] rt_e, input logic [4:0] dest_e,
                                input logic rw, input logic mtr, input logic dst,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input logic fad, input logic fbd, input logic st, input logic busy);
        vec_t t;
        t.name = n; t.rs_d = rs_d; t.rt_d = rt_d; t.br = br; t.hilo = hilo; t.dv = dv;
        t.rs_e = rs_e; t.rt_e = rt_e; t.dest_e = dest_e; t.rw = rw; t.mtr = mtr; t.dst = dst;
        t.exp = {fa, fb, fad, fbd, st, st, st, busy};
        return t;
    endfunction

    task automatic set_inputs(input vec_t t);
        hz.rs_d = t.rs_d; hz.rt_d = t.rt_d; hz.branch_d = t.br;
        hz.hilo_read_d = t.hilo; hz.div_d = t.dv;
        hz.rs_e = t.rs_e; hz.rt_e = t.rt_e; hz.dest_e = t.dest_e;
        hz.regwrite_e = t.rw; hz.memtoreg_e = t.mtr; hz.div_start_e = t.dst;
    endtask

    task automatic drive(input vec_t t);
        set_inputs(t);
        sb.push_back('{t.name, t.exp});
    endtask

    task automatic check_out();
        sb_t        e;
        logic [9:0] got;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got nothing required an entry");
        end else begin
            e   = sb.pop_front();
            got = {hz.fwd_a_e, hz.fwd_b_e, hz.fwd_a_d, hz.fwd_b_d,
                   hz.stall_f, hz.stall_d, hz.flush_e, hz.div_busy};
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s: got fa,fb,fad,fbd,sf,sd,fl,busy=%b required %b", e.name, got, e.exp);
            end
        end
    endtask

    task automatic step(input vec_t t);
        @(posedge clk);
        #1;
        drive(t);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    vec_t z, rm;

    initial begin
        z = mk("zero", 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0);

        tbl.push_back(mk("idle",           0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk("fwd_prime1",     0,0,0,0,0, 0,0,8, 1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk("fwd_prime2_dec", 8,0,0,0,0, 0,0,8, 1,0,0, 0,0,1,0,0,0));
        tbl.push_back(mk("fwd_mem_wins",   0,0,0,0,0, 8,8,0, 0,0,0, 2,2,0,0,0,0));
        tbl.push_back(mk("fwd_wb",         0,0,0,0,0, 8,3,0, 0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk("zero_prime1",    0,0,0,0,0, 0,0,0, 1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk("zero_prime2",    0,0,0,0,0, 0,0,0, 1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk("fwd_zero",       0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk("lw_use_rt",      0,9,0,0,0, 0,0,9, 1,1,0, 0,0,0,0,1,0));
        tbl.push_back(mk("lw_fwd_b",       0,0,0,0,0, 0,9,0, 0,0,0, 0,2,0,0,0,0));
        tbl.push_back(mk("lw_use_rs",      7,0,0,0,0, 9,0,7, 1,1,0, 1,0,0,0,1,0));
        tbl.push_back(mk("lw_reg0",        0,0,0,0,0, 0,0,0, 1,1,0, 0,0,0,0,0,0));
        tbl.push_back(mk("br_prime_ld",    0,0,0,0,0, 0,0,4, 1,1,0, 0,0,0,0,0,0));
        tbl.push_back(mk("br_ld_mem",      4,0,1,0,0, 0,0,0, 0,0,0, 0,0,1,0,1,0));
        tbl.push_back(mk("br_alu_e",       0,4,1,0,0, 0,0,4, 1,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk("br_alu_mem",     4,4,1,0,0, 0,0,0, 0,0,0, 0,0,1,1,0,0));
        tbl.push_back(mk("no_branch_alu",  3,0,0,0,0, 4,0,3, 1,0,0, 1,0,0,0,0,0));

        dtbl.push_back(mk("div_launch",          0,0,0,1,0, 0,0,0, 0,0,1, 0,0,0,0,0,0));
        dtbl.push_back(mk("div_busy1",           0,0,0,1,0, 0,0,0, 0,0,0, 0,0,0,0,B,B));
        dtbl.push_back(mk("div_restart_ignored", 0,0,0,1,0, 0,0,0, 0,0,1, 0,0,0,0,B,B));
        dtbl.push_back(mk("div_busy_divd",       0,0,0,0,1, 0,0,0, 0,0,0, 0,0,0,0,B,B));
        dtbl.push_back(mk("div_lw_combined",     0,9,0,1,0, 0,0,9, 1,1,0, 0,0,0,0,1,B));
        dtbl.push_back(mk("div_release",         0,0,0,1,0, 0,9,0, 0,0,0, 0,2,0,0,0,0));

        // outputs forced low under clr even with stalling inputs
        #2;
        drive(mk("reset_forced", 9,9,1,1,1, 9,9,9, 1,1,1, 0,0,0,0,0,0));
        @(negedge clk);
        check_out();
        #1;
        set_inputs(z);
        clr = 1'b0;

        foreach (tbl[i]) step(tbl[i]);
        foreach (dtbl[i]) step(dtbl[i]);

        rm = mk("rm_start", 0,6,0,1,0, 0,0,6, 1,1,1, 0,0,0,0,1,0);
        step(rm);
        rm = mk("rm_busy1", 0,6,0,1,0, 0,0,6, 1,1,0, 0,0,0,1,1,B);
        step(rm);

        // assert clr asynchronously in the second busy cycle
        @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        sb.push_back('{"rm_clr_immediate", 10'b0});
        check_out();
        @(posedge clk);
        #2;
        set_inputs(mk("rm_release", 6,6,0,1,0, 6,6,0, 0,0,0, 0,0,0,0,0,0));
        clr = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back('{"rm_shadow_cleared", 10'b0});
        check_out();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
